// File: rtl/cnn_bias_relu_3x3_if.sv
// Pixel and bias stream bundle for the bias/ReLU stage.
// master drives bias and pixel strobes; slave is the stage itself.
interface cnn_bias_relu_3x3_if #(
   parameter int unsigned DATA_WIDTH = 16
) ();
   logic                  valid_bias_in;
   logic [DATA_WIDTH-1:0] bias_in;
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] pxl_in;
   logic [DATA_WIDTH-1:0] pxl_out;
   logic                  valid_out;
   logic                  bias_ready;
   logic                  frame_done;
   logic                  err_early;

   modport master (
      output valid_bias_in, bias_in, valid_in, pxl_in,
      input  pxl_out, valid_out, bias_ready, frame_done, err_early
   );

   modport slave (
      input  valid_bias_in, bias_in, valid_in, pxl_in,
      output pxl_out, valid_out, bias_ready, frame_done, err_early
   );
endinterface

// File: rtl/cnn_bias_relu_3x3.sv
// Per-output-channel bias add, saturation and optional ReLU on a channel-major pixel stream.
// Biases are loaded serially after reset and held until the next reset.
module cnn_bias_relu_3x3 #(
   parameter int unsigned DATA_WIDTH      = 16,
   parameter int unsigned FRAC_BITS       = 8,
   parameter int unsigned IMAGE_WIDTH     = 64,
   parameter int unsigned IMAGE_HEIGHT    = 64,
   parameter int unsigned CHANNEL_NUM_OUT = 64,
   parameter bit          RELU_EN         = 1'b1
) (
   input logic                clk,
   input logic                reset,
   cnn_bias_relu_3x3_if.slave bus
);
   localparam int unsigned IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int unsigned PixW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
   localparam int unsigned ChW  = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
   localparam logic [PixW-1:0] PixLast = PixW'(IMAGE_SIZE - 1);
   localparam logic [ChW-1:0]  ChLast  = ChW'(CHANNEL_NUM_OUT - 1);
   localparam logic [DATA_WIDTH-1:0] SatMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SatMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // Pixel and bias share one fixed-point format, so the add needs no shift.
   if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
      $error("FRAC_BITS must be smaller than DATA_WIDTH");
   end

   typedef enum logic [0:0] {StLoad, StRun} state_e;

   state_e                state_q, state_d;
   logic                  bias_wr, pxl_accept, early_pxl;
   logic [ChW-1:0]        load_ptr_q, ch_cnt_q;
   logic [PixW-1:0]       pix_cnt_q;
   logic                  err_early_q;
   logic [DATA_WIDTH-1:0] bias_mem [CHANNEL_NUM_OUT];
   logic                  s1_valid_q, s1_last_q;
   logic [DATA_WIDTH-1:0] s1_pxl_q, s1_bias_q;
   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH-1:0] sat, res;
   logic                  valid_out_q, frame_done_q;
   logic [DATA_WIDTH-1:0] pxl_out_q;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= StLoad;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad:  if (bus.valid_bias_in && load_ptr_q == ChLast) state_d = StRun;
         StRun:   state_d = StRun;
         default: state_d = StLoad;
      endcase
   end

   always_comb begin
      bias_wr    = 1'b0;
      pxl_accept = 1'b0;
      early_pxl  = 1'b0;
      unique case (state_q)
         StLoad: begin
            bias_wr   = bus.valid_bias_in;
            early_pxl = bus.valid_in;
         end
         StRun:   pxl_accept = bus.valid_in;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         load_ptr_q  <= '0;
         pix_cnt_q   <= '0;
         ch_cnt_q    <= '0;
         err_early_q <= 1'b0;
      end else begin
         if (bias_wr) load_ptr_q <= load_ptr_q + 1'b1;
         if (early_pxl) err_early_q <= 1'b1;
         if (pxl_accept) begin
            if (pix_cnt_q == PixLast) begin
               pix_cnt_q <= '0;
               ch_cnt_q  <= (ch_cnt_q == ChLast) ? '0 : ch_cnt_q + 1'b1;
            end else begin
               pix_cnt_q <= pix_cnt_q + 1'b1;
            end
         end
      end
   end

   // Bias RAM has no reset; it is always rewritten before RUN is reached.
   always_ff @(posedge clk) begin
      if (bias_wr) bias_mem[load_ptr_q] <= bus.bias_in;
      s1_bias_q <= bias_mem[ch_cnt_q];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_pxl_q   <= '0;
      end else begin
         s1_valid_q <= pxl_accept;
         s1_last_q  <= pxl_accept && pix_cnt_q == PixLast && ch_cnt_q == ChLast;
         s1_pxl_q   <= bus.pxl_in;
      end
   end

   always_comb begin
      sum = {s1_pxl_q[DATA_WIDTH-1], s1_pxl_q} + {s1_bias_q[DATA_WIDTH-1], s1_bias_q};
      // Top two bits disagree only on signed overflow.
      if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) sat = sum[DATA_WIDTH] ? SatMin : SatMax;
      else                                      sat = sum[DATA_WIDTH-1:0];
      res = (RELU_EN && sat[DATA_WIDTH-1]) ? '0 : sat;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
         pxl_out_q    <= '0;
      end else begin
         valid_out_q  <= s1_valid_q;
         frame_done_q <= s1_last_q;
         if (s1_valid_q) pxl_out_q <= res;
      end
   end

   assign bus.pxl_out    = pxl_out_q;
   assign bus.valid_out  = valid_out_q;
   assign bus.frame_done = frame_done_q;
   assign bus.err_early  = err_early_q;
   assign bus.bias_ready = (state_q == StRun);
endmodule

// File: tb/tb_cnn_bias_relu_3x3.sv
// Scoreboard bench: one ReLU instance and one bypass instance share the same stimulus.
module tb_cnn_bias_relu_3x3;
   localparam int unsigned DW  = 16;
   localparam int unsigned IW  = 2;
   localparam int unsigned IH  = 2;
   localparam int unsigned CH  = 2;
   localparam int unsigned PIX = IW * IH;

   typedef struct {
      logic [DW-1:0] pxl;
      logic          done;
      int            cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cnn_bias_relu_3x3_if #(.DATA_WIDTH(DW)) if_r ();
   cnn_bias_relu_3x3_if #(.DATA_WIDTH(DW)) if_b ();

   cnn_bias_relu_3x3 #(
      .DATA_WIDTH(DW), .FRAC_BITS(8), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
      .CHANNEL_NUM_OUT(CH), .RELU_EN(1'b1)
   ) dut_relu (.clk(clk), .reset(reset), .bus(if_r));

   cnn_bias_relu_3x3 #(
      .DATA_WIDTH(DW), .FRAC_BITS(8), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
      .CHANNEL_NUM_OUT(CH), .RELU_EN(1'b0)
   ) dut_byp (.clk(clk), .reset(reset), .bus(if_b));

   assign if_b.valid_bias_in = if_r.valid_bias_in;
   assign if_b.bias_in       = if_r.bias_in;
   assign if_b.valid_in      = if_r.valid_in;
   assign if_b.pxl_in        = if_r.pxl_in;

   logic [DW-1:0] o_pxl [2];
   logic          o_vld [2];
   logic          o_done[2];
   logic          o_rdy [2];
   logic          o_err [2];
   assign o_pxl[0] = if_r.pxl_out;    assign o_pxl[1] = if_b.pxl_out;
   assign o_vld[0] = if_r.valid_out;  assign o_vld[1] = if_b.valid_out;
   assign o_done[0] = if_r.frame_done; assign o_done[1] = if_b.frame_done;
   assign o_rdy[0] = if_r.bias_ready; assign o_rdy[1] = if_b.bias_ready;
   assign o_err[0] = if_r.err_early;  assign o_err[1] = if_b.err_early;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   exp_t exp_q[2][$];

   logic [DW-1:0] m_bias[CH];
   bit            m_run, m_err;
   int            m_ptr, m_pix, m_ch;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] ref_val(input logic [DW-1:0] p, input logic [DW-1:0] b,
                                             input bit relu);
      int s;
      s = int'($signed(p)) + int'($signed(b));
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      return s[DW-1:0];
   endfunction

   // Outputs change only at posedge; sampling here precedes any drive (drives wait #1).
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (o_vld[i]) begin
            if (exp_q[i].size() == 0) begin
               check_eq($sformatf("unexpected valid_out[%0d]", i), 32'(o_vld[i]), 32'd0);
            end else begin
               e = exp_q[i].pop_front();
               check_eq($sformatf("pxl_out[%0d]", i), 32'(o_pxl[i]), 32'(e.pxl));
               check_eq($sformatf("frame_done[%0d]", i), 32'(o_done[i]), 32'(e.done));
               check_eq($sformatf("latency[%0d]", i), cyc, e.cyc);
            end
         end else begin
            check_eq($sformatf("frame_done idle[%0d]", i), 32'(o_done[i]), 32'd0);
            if (exp_q[i].size() > 0 && exp_q[i][0].cyc <= cyc) begin
               check_eq($sformatf("missing valid_out[%0d]", i), 32'(o_vld[i]), 32'd1);
               void'(exp_q[i].pop_front());
            end
         end
      end
   end

   task automatic drive(input bit vb, input logic [DW-1:0] b, input bit vp,
                        input logic [DW-1:0] p);
      exp_t e;
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("bias_ready[%0d]", i), 32'(o_rdy[i]), 32'(m_run));
         check_eq($sformatf("err_early[%0d]", i), 32'(o_err[i]), 32'(m_err));
      end
      if_r.valid_bias_in = vb;
      if_r.bias_in       = b;
      if_r.valid_in      = vp;
      if_r.pxl_in        = p;
      if (vp) begin
         if (m_run) begin
            e.done = (m_pix == PIX - 1) && (m_ch == CH - 1);
            e.cyc  = cyc + 2;
            e.pxl  = ref_val(p, m_bias[m_ch], 1'b1);
            exp_q[0].push_back(e);
            e.pxl  = ref_val(p, m_bias[m_ch], 1'b0);
            exp_q[1].push_back(e);
            if (m_pix == PIX - 1) begin
               m_pix = 0;
               m_ch  = (m_ch == CH - 1) ? 0 : m_ch + 1;
            end else begin
               m_pix++;
            end
         end else begin
            m_err = 1'b1;
         end
      end
      if (vb && !m_run) begin
         m_bias[m_ptr] = b;
         if (m_ptr == CH - 1) m_run = 1'b1;
         m_ptr++;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, '0);
   endtask

   task automatic pix(input logic [DW-1:0] p);
      drive(1'b0, '0, 1'b1, p);
   endtask

   task automatic load(input logic [DW-1:0] b0, input logic [DW-1:0] b1);
      drive(1'b1, b0, 1'b0, '0);
      drive(1'b1, b1, 1'b0, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      reset = 1'b0;
      if_r.valid_bias_in = 1'b0;
      if_r.bias_in       = '0;
      if_r.valid_in      = 1'b0;
      if_r.pxl_in        = '0;
      exp_q[0].delete();
      exp_q[1].delete();
      m_run = 1'b0;
      m_err = 1'b0;
      m_ptr = 0;
      m_pix = 0;
      m_ch  = 0;
      @(negedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("rst valid_out[%0d]", i), 32'(o_vld[i]), 32'd0);
         check_eq($sformatf("rst pxl_out[%0d]", i), 32'(o_pxl[i]), 32'd0);
         check_eq($sformatf("rst frame_done[%0d]", i), 32'(o_done[i]), 32'd0);
         check_eq($sformatf("rst bias_ready[%0d]", i), 32'(o_rdy[i]), 32'd0);
         check_eq($sformatf("rst err_early[%0d]", i), 32'(o_err[i]), 32'd0);
      end
   endtask

   initial begin
      do_reset();

      // Basic add across a channel change.
      load(16'h0100, 16'hFF00);
      for (int k = 0; k < 4; k++) pix(16'h0080);
      for (int k = 0; k < 4; k++) pix(16'h0200);
      idle(4);

      // Negative result (ReLU vs bypass) and positive saturation.
      do_reset();
      load(16'hFF00, 16'h7F00);
      for (int k = 0; k < 4; k++) pix(16'h0080);
      for (int k = 0; k < 4; k++) pix(16'h7F00);
      idle(4);

      // Negative saturation.
      do_reset();
      load(16'h8100, 16'h8100);
      for (int k = 0; k < 8; k++) pix(16'h8100);
      idle(4);

      // Early pixels, including one alongside the last bias; bias strobes in RUN ignored.
      do_reset();
      drive(1'b0, '0, 1'b1, 16'h0123);
      drive(1'b1, 16'h0200, 1'b1, 16'h0111);
      drive(1'b1, 16'hFE00, 1'b1, 16'h0222);
      for (int k = 0; k < 8; k++) drive(1'b1, 16'h7FFF, 1'b1, 16'(16'h0100 * k));
      idle(4);

      // Random gaps over two frames with random data.
      do_reset();
      load(16'($urandom()), 16'($urandom()));
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 8; k++) begin
            idle($urandom_range(0, 3));
            pix(16'($urandom()));
         end
      end
      idle(4);

      // Reset right after the third pixel drops in-flight data.
      do_reset();
      load(16'h0040, 16'hFFC0);
      pix(16'h0010);
      pix(16'hFF00);
      pix(16'h0300);
      do_reset();
      pix(16'h0055);
      pix(16'h0066);
      load(16'h0040, 16'hFFC0);
      for (int k = 0; k < 8; k++) pix(16'($urandom()));
      idle(4);

      for (int i = 0; i < 2; i++)
         check_eq($sformatf("queue drained[%0d]", i), exp_q[i].size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
